// File: rtl/lsu_pkg.sv
// Shared definitions for the byte-serial load/store master.
//   SZ_*       : request size encodings (byte, half, word, double)
//   lsu_state_e: controller state encoding
//   bytes_of() : number of byte accesses for a size encoding (1/2/4/8)
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } lsu_state_e;

    function automatic logic [3:0] bytes_of(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Load result extension: keeps the low 1/2/4/8 bytes of the captured data and
// fills the upper bits with the field's sign bit (signed) or zeros (unsigned).
//   i_capture  : assembled little-endian load bytes
//   i_size     : size encoding (SZ_B..SZ_D)
//   i_unsigned : 1 = zero-extend, 0 = sign-extend
//   o_result   : extended 64-bit result
module lsu_load_extend
    import lsu_pkg::*;
(
    input  logic [63:0] i_capture,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [63:0] o_result
);

    logic [63:0] w_keep_mask;
    logic        w_sign;

    // The double size keeps every bit, so its fill mask is empty and the
    // capture passes through untouched.
    always_comb begin
        w_keep_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        w_sign      = 1'b0;
        unique case (i_size)
            SZ_B: begin
                w_keep_mask = 64'h0000_0000_0000_00FF;
                w_sign      = i_capture[7];
            end
            SZ_H: begin
                w_keep_mask = 64'h0000_0000_0000_FFFF;
                w_sign      = i_capture[15];
            end
            SZ_W: begin
                w_keep_mask = 64'h0000_0000_FFFF_FFFF;
                w_sign      = i_capture[31];
            end
            default: begin
                w_keep_mask = 64'hFFFF_FFFF_FFFF_FFFF;
                w_sign      = i_capture[63];
            end
        endcase
    end

    assign o_result = (i_capture & w_keep_mask)
                    | ((w_sign && !i_unsigned) ? ~w_keep_mask : 64'd0);

endmodule

// File: rtl/lsu_byte_master.sv
// Byte-serial load/store master. Accepts one request at a time from the core,
// walks it out as 1/2/4/8 little-endian byte accesses, then pulses a response.
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid/req_ready   : request handshake (ready only while idle)
//   req_write/size/unsigned/addr/wdata : request fields, latched on accept
//   resp_valid/err/rdata  : one-cycle completion pulse, error flag, load data
//   busy                  : controller not idle
//   mem_addr/wdata/we/re  : byte memory port, driven only during accesses
//   mem_rdata             : same-cycle read data for mem_addr
module lsu_byte_master
    import lsu_pkg::*;
#(
    parameter int ADDR_W      = 64,
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [63:0]       resp_rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata
);

    lsu_state_e        r_state;
    logic              r_write;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic [ADDR_W-1:0] r_addr;
    logic [63:0]       r_wdata;
    logic [2:0]        r_cnt;
    logic              r_err;
    logic [63:0]       r_capture;

    logic [3:0]        w_nbytes;
    logic [2:0]        w_align_mask;
    logic              w_misalign;
    logic              w_last;
    logic              w_in_access;
    logic [63:0]       w_ext;

    // Alignment only depends on the low three address bits since N <= 8.
    assign w_nbytes     = bytes_of(req_size);
    assign w_align_mask = 3'(w_nbytes - 4'd1);
    assign w_misalign   = CHECK_ALIGN && ((req_addr[2:0] & w_align_mask) != 3'd0);
    assign w_last       = (r_cnt == 3'(bytes_of(r_size) - 4'd1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_write    <= 1'b0;
            r_size     <= SZ_B;
            r_unsigned <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= 64'd0;
            r_cnt      <= 3'd0;
            r_err      <= 1'b0;
            r_capture  <= 64'd0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_write    <= req_write;
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_addr     <= req_addr;
                        r_wdata    <= req_wdata;
                        r_cnt      <= 3'd0;
                        r_err      <= w_misalign;
                        r_capture  <= 64'd0;
                        r_state    <= w_misalign ? ST_RESP : ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (!r_write) begin
                        r_capture[{r_cnt, 3'b000} +: 8] <= mem_rdata;
                    end
                    if (w_last) begin
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    lsu_load_extend u_extend (
        .i_capture  (r_capture),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_result   (w_ext)
    );

    // Memory strobes decode straight from state so that an asynchronous reset
    // drops them immediately, mid-access.
    assign w_in_access = (r_state == ST_ACCESS);
    assign mem_we      = w_in_access && r_write;
    assign mem_re      = w_in_access && !r_write;
    assign mem_addr    = w_in_access ? (r_addr + ADDR_W'(r_cnt)) : '0;
    assign mem_wdata   = mem_we ? r_wdata[{r_cnt, 3'b000} +: 8] : 8'd0;

    assign req_ready   = (r_state == ST_IDLE);
    assign busy        = !req_ready;
    assign resp_valid  = (r_state == ST_RESP);
    assign resp_err    = resp_valid && r_err;
    assign resp_rdata  = (resp_valid && !r_write && !r_err) ? w_ext : 64'd0;

endmodule

// File: tb/tb_lsu_byte_master.sv
// Scoreboard bench for lsu_byte_master: two instances (alignment checked and
// unchecked) on small byte memories, plus the extension block on its own.
module tb_lsu_byte_master;
    import lsu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        mem_clr;
    logic        req_valid, req_valid_b, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [63:0] req_addr, req_wdata;

    logic        req_ready, resp_valid, resp_err, busy, mem_we, mem_re;
    logic [63:0] resp_rdata, mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;

    logic        req_ready_b, resp_valid_b, resp_err_b, busy_b, mem_we_b, mem_re_b;
    logic [63:0] resp_rdata_b, mem_addr_b;
    logic [7:0]  mem_wdata_b, mem_rdata_b;

    logic [63:0] ext_cap, ext_out;
    logic [1:0]  ext_size;
    logic        ext_uns;

    lsu_byte_master #(.ADDR_W(64), .CHECK_ALIGN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_err(resp_err), .resp_rdata(resp_rdata), .busy(busy),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_re(mem_re), .mem_rdata(mem_rdata)
    );

    lsu_byte_master #(.ADDR_W(64), .CHECK_ALIGN(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid_b),
        .resp_err(resp_err_b), .resp_rdata(resp_rdata_b), .busy(busy_b),
        .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_we(mem_we_b),
        .mem_re(mem_re_b), .mem_rdata(mem_rdata_b)
    );

    lsu_load_extend u_ext (
        .i_capture(ext_cap), .i_size(ext_size), .i_unsigned(ext_uns), .o_result(ext_out)
    );

    // Byte memories (32 bytes, address wraps on the low 5 bits).
    logic [7:0] mem_a [32];
    logic [7:0] mem_b [32];
    logic [7:0] ref_a [32];
    logic [7:0] saved [32];

    assign mem_rdata   = mem_a[mem_addr[4:0]];
    assign mem_rdata_b = mem_b[mem_addr_b[4:0]];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 32; i++) begin
                mem_a[i] <= 8'h00;
                mem_b[i] <= 8'h00;
            end
        end else begin
            if (mem_we)   mem_a[mem_addr[4:0]]   <= mem_wdata;
            if (mem_we_b) mem_b[mem_addr_b[4:0]] <= mem_wdata_b;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ext_model(input logic [63:0] c, input logic [1:0] sz, input logic u);
        int n;
        logic [63:0] v;
        n = 1 << sz;
        v = c;
        if (n < 8) begin
            v = c & ((64'd1 << (8 * n)) - 64'd1);
            if (!u && c[8 * n - 1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
        end
        return v;
    endfunction

    typedef struct { int cyc; logic we; logic [63:0] addr; logic [7:0] wd; } memop_t;
    typedef struct { int cyc; logic err; logic [63:0] rdata; } resp_t;
    memop_t memq [$];
    resp_t  respq[$];

    // Monitor for the checked instance: every byte access and response is
    // matched against the next expected entry, including its cycle.
    always @(negedge clk) begin
        memop_t m;
        resp_t  r;
        if (rst_n && !mem_clr) begin
            if (mem_we || mem_re) begin
                chk("mem_excl", 64'(mem_we & mem_re), 64'd0);
                if (memq.size() == 0) begin
                    chk("mem_unexpected", 64'({mem_we, mem_re}), 64'd0);
                end else begin
                    m = memq.pop_front();
                    chk("mem_cyc", 64'(cyc), 64'(m.cyc));
                    chk("mem_we", 64'(mem_we), 64'(m.we));
                    chk("mem_re", 64'(mem_re), 64'(!m.we));
                    chk("mem_addr", mem_addr, m.addr);
                    chk("mem_wdata", 64'(mem_wdata), 64'(m.wd));
                end
            end
            if (resp_valid) begin
                if (respq.size() == 0) begin
                    chk("resp_unexpected", 64'(resp_valid), 64'd0);
                end else begin
                    r = respq.pop_front();
                    chk("resp_cyc", 64'(cyc), 64'(r.cyc));
                    chk("resp_err", 64'(resp_err), 64'(r.err));
                    chk("resp_rdata", resp_rdata, r.rdata);
                end
            end
        end
    end

    // Called at a negedge; leaves req_valid high and returns at the negedge
    // following the accept edge. acc is the cycle number of the accept edge.
    task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                         input logic [63:0] a, input logic [63:0] wd, output int acc);
        int n;
        int t;
        logic err;
        logic [63:0] v;
        memop_t m;
        resp_t r;
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
        req_addr = a; req_wdata = wd;
        t = 0;
        while (!req_ready && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 64'(req_ready), 64'd1);
            acc = -1;
            req_valid = 1'b0;
            return;
        end
        acc = cyc + 1;
        n = 1 << sz;
        err = (a % 64'(n)) != 64'd0;
        v = 64'd0;
        if (!err) begin
            for (int k = 0; k < n; k++) begin
                m.cyc = acc + k; m.we = w; m.addr = a + 64'(k);
                m.wd = w ? wd[8 * k +: 8] : 8'h00;
                memq.push_back(m);
                if (w) ref_a[(a[4:0] + 5'(k))] = wd[8 * k +: 8];
                else   v[8 * k +: 8] = ref_a[(a[4:0] + 5'(k))];
            end
            if (!w) v = ext_model(v, sz, u);
        end
        r.cyc = err ? acc : acc + n;
        r.err = err;
        r.rdata = v;
        respq.push_back(r);
        @(negedge clk);
    endtask

    task automatic drain();
        for (int t = 0; t < 40 && (respq.size() != 0 || memq.size() != 0); t++) @(negedge clk);
        chk("drain_resp", 64'(respq.size()), 64'd0);
        chk("drain_mem", 64'(memq.size()), 64'd0);
    endtask

    task automatic wait_ready_b();
        for (int t = 0; t < 20 && !req_ready_b; t++) @(negedge clk);
        chk("b_ready", 64'(req_ready_b), 64'd1);
    endtask

    initial begin
        int acc, acc2;
        req_valid = 0; req_valid_b = 0; req_write = 0; req_size = SZ_B;
        req_unsigned = 0; req_addr = 0; req_wdata = 0;
        ext_cap = 0; ext_size = SZ_B; ext_uns = 0;
        for (int i = 0; i < 32; i++) ref_a[i] = 8'h00;
        mem_clr = 1'b1;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_err", 64'(resp_err), 64'd0);
        chk("rst_resp_rdata", resp_rdata, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_mem_strobes", 64'({mem_we, mem_re}), 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mem_clr = 1'b0;
        @(negedge clk);

        // Double store then double load at 8.
        issue(1'b1, SZ_D, 1'b0, 64'd8, 64'h1122334455667788, acc); req_valid = 0;
        issue(1'b0, SZ_D, 1'b0, 64'd8, 64'd0, acc); req_valid = 0;
        // Word 0x80000000 at 16, signed and unsigned word loads, signed byte load.
        issue(1'b1, SZ_W, 1'b0, 64'd16, 64'h0000_0000_8000_0000, acc); req_valid = 0;
        issue(1'b0, SZ_W, 1'b0, 64'd16, 64'd0, acc); req_valid = 0;
        issue(1'b0, SZ_W, 1'b1, 64'd16, 64'd0, acc); req_valid = 0;
        issue(1'b0, SZ_B, 1'b0, 64'd8, 64'd0, acc); req_valid = 0;
        issue(1'b0, SZ_H, 1'b1, 64'd10, 64'd0, acc); req_valid = 0;
        // Misaligned half load: error, no memory access.
        issue(1'b0, SZ_H, 1'b0, 64'd3, 64'd0, acc); req_valid = 0;
        drain();
        chk("busy_idle", 64'(busy), 64'd0);

        // Unchecked instance: wrapping half store then load at all-ones.
        wait_ready_b();
        req_valid_b = 1; req_write = 1; req_size = SZ_H; req_unsigned = 0;
        req_addr = 64'hFFFF_FFFF_FFFF_FFFF; req_wdata = 64'h1234;
        @(negedge clk); req_valid_b = 0;
        chk("b_st_addr0", mem_addr_b, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("b_st_data0", 64'({mem_we_b, mem_wdata_b}), 64'h134);
        chk("b_busy", 64'(busy_b), 64'd1);
        @(negedge clk);
        chk("b_st_addr1", mem_addr_b, 64'd0);
        chk("b_st_data1", 64'({mem_we_b, mem_wdata_b}), 64'h112);
        @(negedge clk);
        chk("b_st_resp", 64'({resp_valid_b, resp_err_b}), 64'b10);
        chk("b_st_rdata", resp_rdata_b, 64'd0);
        wait_ready_b();
        req_valid_b = 1; req_write = 0; req_unsigned = 1;
        @(negedge clk); req_valid_b = 0;
        chk("b_ld_addr0", mem_addr_b, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("b_ld_re0", 64'({mem_re_b, mem_we_b}), 64'b10);
        @(negedge clk);
        chk("b_ld_addr1", mem_addr_b, 64'd0);
        @(negedge clk);
        chk("b_ld_resp", 64'({resp_valid_b, resp_err_b}), 64'b10);
        chk("b_ld_rdata", resp_rdata_b, 64'h1234);
        @(negedge clk);

        // Reset after the third byte of a double store at 0.
        saved = ref_a;
        issue(1'b1, SZ_D, 1'b0, 64'd0, 64'hA7A6A5A4A3A2A1A0, acc); req_valid = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        memq.delete();
        respq.delete();
        chk("mid_rst_we", 64'(mem_we), 64'd0);
        chk("mid_rst_ready", 64'(req_ready), 64'd1);
        chk("mid_rst_resp", 64'(resp_valid), 64'd0);
        ref_a = saved;
        ref_a[0] = 8'hA0; ref_a[1] = 8'hA1; ref_a[2] = 8'hA2;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 8; i++) chk($sformatf("mid_rst_mem%0d", i), 64'(mem_a[i]), 64'(ref_a[i]));

        // Back-to-back with req_valid held: store byte, then load byte.
        issue(1'b1, SZ_B, 1'b0, 64'd0, 64'hAB, acc);
        issue(1'b0, SZ_B, 1'b0, 64'd0, 64'd0, acc2);
        req_valid = 0;
        chk("b2b_accept", 64'(acc2), 64'(acc + 3));
        drain();

        // Extension block on its own.
        for (int c = 0; c < 2; c++) begin
            for (int s = 0; s < 4; s++) begin
                for (int u = 0; u < 2; u++) begin
                    ext_cap = (c == 0) ? 64'hF0E1D2C3B4A59687 : 64'h0123456789AB4D7F;
                    ext_size = 2'(s);
                    ext_uns = u[0];
                    #1;
                    chk($sformatf("ext_c%0d_s%0d_u%0d", c, s, u), ext_out, ext_model(ext_cap, ext_size, ext_uns));
                end
            end
        end
        ext_cap = 64'h0000_0000_0000_0080; ext_size = SZ_B; ext_uns = 1'b0;
        #1 chk("ext_b80", ext_out, 64'hFFFF_FFFF_FFFF_FF80);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
